stream_credit_gate_with_flush: RTL

Upstream feeder for the flushable stream FIFO wrapper, which accepts writes only while not full and exposes neither ready, full nor empty. This block takes a valid/ready stream from the producer and registers it for one cycle. It tracks downstream FIFO occupancy with a shadow counter, so it never presents a write the FIFO would silently drop. It also exports mirrored empty/full/count status to the surrounding control logic.

---
 rtl/stream_credit_gate_with_flush.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/stream_credit_gate_with_flush.sv
// -----------------------------------------------------------------------------
// stream_credit_gate_with_flush
//
// Feeds the flushable stream FIFO wrapper from a valid/ready producer. The FIFO
// silently drops writes while full and exposes no status. This block keeps a
// shadow copy of its occupancy so it never presents a write the FIFO would drop,
// and it mirrors empty/full/count to the surrounding control logic.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   flush        same flush pulse that clears the downstream FIFO
//   in_valid_i   producer beat valid
//   in_ready_o   block accepts a beat this cycle
//   in_data_i    producer payload
//   out_valid_o  registered write strobe to the FIFO (w_valid_i)
//   out_data_o   registered write data to the FIFO (w_data_i)
//   pop_i        same read-ready that drives the FIFO read side
//   occ_o        shadow FIFO occupancy, 0..FIFO_DEPTH
//   empty_o      occ_o == 0
//   full_o       occ_o == FIFO_DEPTH
// -----------------------------------------------------------------------------
module stream_credit_gate_with_flush #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic                  pop_i,
    output logic [CW-1:0]         occ_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_CW  = CW'(FIFO_DEPTH);

    logic                  stage_v_q;
    logic                  stage_v_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [CW-1:0]         occ_q;
    logic [CW-1:0]         occ_d;
    logic                  empty_q;
    logic                  full_q;

    logic [CW:0]           credit_s;
    logic                  in_ready_s;
    logic                  fire_s;
    logic                  pop_eff_s;

    // Credit check, handshake and next-state computation.
    always_comb begin
        // The staged beat counts as already used: it is written next edge.
        credit_s   = {1'b0, occ_q} + {{CW{1'b0}}, stage_v_q};
        in_ready_s = rst_n && !flush && (credit_s < DEPTH_EXT);
        fire_s     = in_valid_i && in_ready_s;
        // The FIFO ignores pops while empty; mirror that exactly.
        pop_eff_s  = pop_i && (occ_q != {CW{1'b0}});

        stage_v_d  = 1'b0;
        data_d     = data_q;
        occ_d      = occ_q;
        if (flush) begin
            // A beat staged this cycle is written but wiped by the FIFO flush.
            stage_v_d = 1'b0;
            data_d    = data_q;
            occ_d     = {CW{1'b0}};
        end else begin
            stage_v_d = fire_s;
            if (fire_s) begin
                data_d = in_data_i;
            end else begin
                data_d = data_q;
            end
            // Cannot wrap: occ + stage_v never exceeds FIFO_DEPTH.
            occ_d = occ_q + CW'(stage_v_q) - CW'(pop_eff_s);
        end
    end

    // State and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_v_q <= 1'b0;
            data_q    <= {DATA_WIDTH{1'b0}};
            occ_q     <= {CW{1'b0}};
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            stage_v_q <= stage_v_d;
            data_q    <= data_d;
            occ_q     <= occ_d;
            empty_q   <= (occ_d == {CW{1'b0}});
            full_q    <= (occ_d == DEPTH_CW);
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = stage_v_q;
    assign out_data_o  = data_q;
    assign occ_o       = occ_q;
    assign empty_o     = empty_q;
    assign full_o      = full_q;

    stream_credit_gate_with_flush_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .occ     (occ_q),
        .stage_v (stage_v_q)
    );

endmodule

// -----------------------------------------------------------------------------
// stream_credit_gate_with_flush_chk
//
// Invariant checker: staged beat plus shadow occupancy never exceed the FIFO
// depth, so the FIFO is never written while full and occ never overflows.
// Ports: clk, rst_n, occ (shadow occupancy), stage_v (output register valid).
// -----------------------------------------------------------------------------
module stream_credit_gate_with_flush_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] occ,
    input logic          stage_v
);

    localparam logic [CW:0] DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, occ} + {{CW{1'b0}}, stage_v}) <= DEPTH_EXT));

endmodule
